// File: rtl/demux_pkg.sv
// Shared constants and slot state encoding for the 1:2 stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot with valid/ready handshake and optional beat counter.
// Latency: one cycle from load to out_valid.
// Backpressure: slot_rdy is high when empty or draining this cycle; data held while stalled.
// Optional: DEMUX_BEAT_CNT_EN adds a wrapping count of completed output handshakes.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             slot_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DEMUX_BEAT_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drain;

  // State register: slot state and held payload, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next state: a load always wins (fills or replaces), otherwise a drain empties the slot
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Outputs: valid is masked during reset so no handshake completes on a beat being discarded
  always_comb begin
    out_valid = (state_q == SLOT_FULL) && !rst;
    out_data  = data_q;
    drain     = out_valid && out_ready;
    slot_rdy  = (state_q == SLOT_EMPTY) || out_ready;
  end

`ifdef DEMUX_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Delivered-beat counter register, wraps naturally at full scale
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count each completed output handshake
  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, drain};
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: rtl/demux1to2_stream.sv
// Routes one valid/ready input stream to one of two registered output slots, chosen per beat by in_sel.
// Latency: one cycle from accept to outk_valid.
// Backpressure: in_ready follows only the selected slot; a stalled port never blocks the other.
// Optional: DEMUX_BEAT_CNT_EN adds cnt0/cnt1 delivered-beat counters.
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_BEAT_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic slot0_rdy, slot1_rdy;
  logic accept, load0, load1;

  // Ready mux on the selected slot only, and load-enable decode of the accepted beat
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = in_sel ? slot1_rdy : slot0_rdy;
    end
    accept = in_valid && in_ready;
    load0  = accept && !in_sel;
    load1  = accept && in_sel;
  end

  demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (in_data),
    .slot_rdy  (slot0_rdy),
    .out_data  (out0_data),
    .out_valid (out0_valid),
    .out_ready (out0_ready)
`ifdef DEMUX_BEAT_CNT_EN
    ,
    .cnt       (cnt0)
`endif
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (in_data),
    .slot_rdy  (slot1_rdy),
    .out_data  (out1_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready)
`ifdef DEMUX_BEAT_CNT_EN
    ,
    .cnt       (cnt1)
`endif
  );

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed bench for demux1to2_stream with a per-port scoreboard of accepted beats.
module tb_demux1to2_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [3:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
`ifdef DEMUX_BEAT_CNT_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_dlv0 = 0;
  int n_dlv1 = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  demux1to2_stream #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX_BEAT_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop/compare on output handshakes, push on input accepts, flush on reset
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out0_valid && out0_ready) begin
        n_dlv0++;
        if (q0.size() == 0) chk("out0_unexpected_beat", 32'(out0_data), 32'hdead);
        else chk("out0_data", 32'(out0_data), 32'(q0.pop_front()));
      end
      if (out1_valid && out1_ready) begin
        n_dlv1++;
        if (q1.size() == 0) chk("out1_unexpected_beat", 32'(out1_data), 32'hdead);
        else chk("out1_data", 32'(out1_data), 32'(q1.pop_front()));
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else q0.push_back(in_data);
      end
    end
  end

  initial begin
    int d0, d1;
    // ---- reset held two cycles with a beat offered
    rst = 1'b1; in_valid = 1'b1; in_data = 4'hf; in_sel = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out0_valid", 32'(out0_valid), 0);
    chk("rst_out1_valid", 32'(out1_valid), 0);
    chk("rst_out0_data", 32'(out0_data), 0);
    chk("rst_out1_data", 32'(out1_data), 0);
    tick();
    chk("rst2_in_ready", 32'(in_ready), 0);
    chk("rst2_out0_valid", 32'(out0_valid), 0);
`ifdef DEMUX_BEAT_CNT_EN
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_out0_valid", 32'(out0_valid), 0);
    chk("post_rst_out1_valid", 32'(out1_valid), 0);

    // ---- basic routing, back to back
    in_valid = 1'b1; in_data = 4'd1; in_sel = 1'b0; #1;
    chk("route_in_ready_a", 32'(in_ready), 1);
    tick();
    chk("route_out0_valid_a", 32'(out0_valid), 1);
    chk("route_out0_data_a", 32'(out0_data), 1);
    in_data = 4'd9; in_sel = 1'b1; #1;
    chk("route_in_ready_b", 32'(in_ready), 1);
    tick();
    chk("route_out1_valid_b", 32'(out1_valid), 1);
    chk("route_out1_data_b", 32'(out1_data), 9);
    chk("route_out0_drained", 32'(out0_valid), 0);
    in_data = 4'd3; in_sel = 1'b0;
    tick();
    chk("route_out0_data_c", 32'(out0_data), 3);
    chk("route_out0_valid_c", 32'(out0_valid), 1);
    chk("route_out1_drained", 32'(out1_valid), 0);
    in_valid = 1'b0;
    tick();
    chk("route_idle_out0_valid", 32'(out0_valid), 0);
    chk("route_q0_empty", q0.size(), 0);
    chk("route_q1_empty", q1.size(), 0);

    // ---- backpressure on port 0, port 1 keeps flowing
    out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'd5; in_sel = 1'b0;
    tick();
    chk("bp_out0_valid", 32'(out0_valid), 1);
    chk("bp_out0_data", 32'(out0_data), 5);
    in_data = 4'd6; #1;
    chk("bp_in_ready_blocked", 32'(in_ready), 0);
    tick();
    chk("bp_out0_held", 32'(out0_data), 5);
    in_sel = 1'b1; in_data = 4'd12; #1;
    chk("bp_in_ready_other", 32'(in_ready), 1);
    tick();
    chk("bp_out1_valid", 32'(out1_valid), 1);
    chk("bp_out1_data", 32'(out1_data), 12);
    chk("bp_out0_still", 32'(out0_data), 5);
    chk("bp_out0_valid_still", 32'(out0_valid), 1);
    in_valid = 1'b0;
    tick();
    chk("bp_out1_drained", 32'(out1_valid), 0);

    // ---- simultaneous drain and load on port 0
    d0 = n_dlv0;
    out0_ready = 1'b1; in_valid = 1'b1; in_data = 4'd7; in_sel = 1'b0; #1;
    chk("dl_in_ready_a", 32'(in_ready), 1);
    tick();
    chk("dl_out0_data_7", 32'(out0_data), 7);
    in_data = 4'd8;
    tick();
    chk("dl_out0_valid_kept", 32'(out0_valid), 1);
    chk("dl_out0_data_8", 32'(out0_data), 8);
    in_valid = 1'b0;
    tick();
    chk("dl_out0_empty", 32'(out0_valid), 0);
    chk("dl_delivered_count", n_dlv0 - d0, 3);
    chk("dl_q0_empty", q0.size(), 0);

    // ---- mid-operation reset discards the held beat on port 1
    d1 = n_dlv1;
    out1_ready = 1'b0; in_valid = 1'b1; in_data = 4'd14; in_sel = 1'b1;
    tick();
    chk("mr_out1_data", 32'(out1_data), 14);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mr_out1_valid", 32'(out1_valid), 0);
    chk("mr_out1_data_clr", 32'(out1_data), 0);
    rst = 1'b0; out1_ready = 1'b1;
    tick();
    tick();
    chk("mr_out1_valid_after", 32'(out1_valid), 0);
    chk("mr_not_delivered", n_dlv1 - d1, 0);
    chk("mr_q1_empty", q1.size(), 0);
`ifdef DEMUX_BEAT_CNT_EN
    chk("mr_cnt1_clr", 32'(cnt1), 0);
`endif

    // ---- 256 back-to-back beats to port 0 at full rate
    d0 = n_dlv0;
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_data = 4'(i * 7 + 3); #1;
      if (i == 0 || i == 255) chk("stream_in_ready", 32'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("stream_delivered", n_dlv0 - d0, 256);
    chk("stream_q0_empty", q0.size(), 0);
`ifdef DEMUX_BEAT_CNT_EN
    chk("stream_cnt0_wrap", 32'(cnt0), 0);
    chk("stream_cnt1_zero", 32'(cnt1), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
